// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// The master issues start/bin and reads back the result and status flags.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// One input bit is consumed per clock, so a WIDTH-bit operand takes WIDTH
// clocks after acceptance. Bits that fall off the top digit are folded into
// an overflow flag; the retained digits then equal bin mod 10^DIGITS.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shift_q,    shift_d;
    logic [BCD_W-1:0]   scratch_q,  scratch_d;
    logic               ovf_acc_q,  ovf_acc_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted_bcd;
    logic               bit_out;

    // Add-3 correction: any digit of 5 or more is bumped so the following
    // doubling carries correctly into the next decimal digit.
    always_comb begin
        adjusted = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift the corrected digits left by one, pulling in the next binary MSB;
    // the bit pushed out of the top digit is worth 10^DIGITS.
    always_comb begin
        shifted_bcd = {adjusted[BCD_W-2:0], shift_q[WIDTH-1]};
        bit_out     = adjusted[BCD_W-1];
    end

    // Next-state logic for the IDLE/SHIFT controller and its datapath.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    ovf_acc_d = 1'b0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                scratch_d = shifted_bcd;
                ovf_acc_d = ovf_acc_q | bit_out;
                count_d   = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    bcd_d      = shifted_bcd;
                    overflow_d = ovf_acc_q | bit_out;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// share one clock; expected results come from plain decimal arithmetic.
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) if3 ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) if2 ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of v, truncated to the given digit count.
    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int digits);
        int p;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        return (v >= p);
    endfunction

    // Runs one conversion on the chosen instance; lat is the number of edges
    // from acceptance to done (-1 on timeout), busy_cnt the cycles busy was seen.
    task automatic do_conv(input int which, input logic [7:0] value,
                           output logic [11:0] res, output logic ovf,
                           output int lat, output int busy_cnt,
                           output logic done_after);
        logic d;
        @(negedge clk);
        if (which == 3) begin if3.start = 1'b1; if3.bin = value; end
        else            begin if2.start = 1'b1; if2.bin = value; end
        @(negedge clk);
        if (which == 3) begin if3.start = 1'b0; if3.bin = 8'($urandom); end
        else            begin if2.start = 1'b0; if2.bin = 8'($urandom); end
        busy_cnt = (which == 3) ? int'(if3.busy) : int'(if2.busy);
        lat = -1;
        res = '0;
        ovf = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            d = (which == 3) ? if3.done : if2.done;
            if (d) begin
                lat = i;
                res = (which == 3) ? if3.bcd : {4'h0, if2.bcd};
                ovf = (which == 3) ? if3.overflow : if2.overflow;
                break;
            end
            busy_cnt += (which == 3) ? int'(if3.busy) : int'(if2.busy);
        end
        @(negedge clk);
        done_after = (which == 3) ? if3.done : if2.done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        if3.start = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (if3.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", if3.busy); end
        n_cmp++; if (if3.done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", if3.done); end
        n_cmp++; if (if3.bcd !== 12'h000) begin n_err++; $display("[TB] FAIL reset_bcd got %h want 000", if3.bcd); end
        n_cmp++; if (if3.overflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf got %b want 0", if3.overflow); end
        n_cmp++; if (if2.bcd !== 8'h00) begin n_err++; $display("[TB] FAIL reset_bcd2 got %h want 00", if2.bcd); end
        if3.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [11:0] res; logic ovf; int lat; int bc; logic da;
        do_conv(3, 8'd0, res, ovf, lat, bc, da);
        n_cmp++; if (lat !== 8) begin n_err++; $display("[TB] FAIL zero_latency got %0d want 8", lat); end
        n_cmp++; if (res !== 12'h000) begin n_err++; $display("[TB] FAIL zero_bcd got %h want 000", res); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL zero_ovf got %b want 0", ovf); end
    endtask

    task automatic test_max();
        logic [11:0] res; logic ovf; int lat; int bc; logic da;
        do_conv(3, 8'd255, res, ovf, lat, bc, da);
        n_cmp++; if (res !== 12'h255) begin n_err++; $display("[TB] FAIL max_bcd got %h want 255", res); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL max_ovf got %b want 0", ovf); end
        n_cmp++; if (bc !== 8) begin n_err++; $display("[TB] FAIL max_busy_cycles got %0d want 8", bc); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("[TB] FAIL max_done_width got %b want 0 after pulse", da); end
    endtask

    task automatic test_sweep();
        logic [11:0] res; logic ovf; int lat; int bc; logic da;
        int bad_digits;
        bad_digits = 0;
        for (int v = 0; v <= 12; v++) begin
            do_conv(3, 8'(v), res, ovf, lat, bc, da);
            n_cmp++; if (res !== ref_bcd(v, 3)) begin n_err++; $display("[TB] FAIL sweep12_bcd bin=%0d got %h want %h", v, res, ref_bcd(v, 3)); end
        end
        for (int v = 0; v <= 255; v++) begin
            do_conv(3, 8'(v), res, ovf, lat, bc, da);
            n_cmp++; if (res !== ref_bcd(v, 3) || ovf !== ref_ovf(v, 3) || lat !== 8) begin
                n_err++;
                $display("[TB] FAIL sweep_bcd bin=%0d got %h/%b/%0d want %h/%b/8", v, res, ovf, lat, ref_bcd(v, 3), ref_ovf(v, 3));
            end
            for (int k = 0; k < 3; k++) if (res[4*k +: 4] > 4'd9) bad_digits++;
        end
        n_cmp++; if (bad_digits !== 0) begin n_err++; $display("[TB] FAIL sweep_digit_range got %0d bad digits want 0", bad_digits); end
    endtask

    task automatic test_two_digits();
        logic [11:0] res; logic ovf; int lat; int bc; logic da;
        int v;
        do_conv(2, 8'd123, res, ovf, lat, bc, da);
        n_cmp++; if (res[7:0] !== 8'h23) begin n_err++; $display("[TB] FAIL d2_123_bcd got %h want 23", res[7:0]); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("[TB] FAIL d2_123_ovf got %b want 1", ovf); end
        do_conv(2, 8'd99, res, ovf, lat, bc, da);
        n_cmp++; if (res[7:0] !== 8'h99) begin n_err++; $display("[TB] FAIL d2_99_bcd got %h want 99", res[7:0]); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL d2_99_ovf got %b want 0", ovf); end
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(255, 0));
            do_conv(2, 8'(v), res, ovf, lat, bc, da);
            n_cmp++; if (res[7:0] !== ref_bcd(v, 2)[7:0] || ovf !== ref_ovf(v, 2)) begin
                n_err++;
                $display("[TB] FAIL d2_random bin=%0d got %h/%b want %h/%b", v, res[7:0], ovf, ref_bcd(v, 2)[7:0], ref_ovf(v, 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = -1;
        @(negedge clk);
        if3.start = 1'b1; if3.bin = 8'd200;
        @(negedge clk);
        if3.start = 1'b0; if3.bin = 8'($urandom);
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin if3.start = 1'b1; if3.bin = 8'd77; end
            @(negedge clk);
            if (i == 3) if3.start = 1'b0;
            if (if3.done) begin lat = i; break; end
        end
        n_cmp++; if (lat !== 8) begin n_err++; $display("[TB] FAIL ignore_latency got %0d want 8", lat); end
        n_cmp++; if (if3.bcd !== 12'h200) begin n_err++; $display("[TB] FAIL ignore_bcd got %h want 200", if3.bcd); end
        if3.start = 1'b1; if3.bin = 8'd42;
        @(negedge clk);
        if3.start = 1'b0; if3.bin = 8'($urandom);
        n_cmp++; if (if3.busy !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_accept got busy=%b want 1", if3.busy); end
        n_cmp++; if (if3.bcd !== 12'h200) begin n_err++; $display("[TB] FAIL b2b_hold got %h want 200", if3.bcd); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if3.done) begin lat = i; break; end
        end
        n_cmp++; if (lat !== 8) begin n_err++; $display("[TB] FAIL b2b_latency got %0d want 8", lat); end
        n_cmp++; if (if3.bcd !== 12'h042) begin n_err++; $display("[TB] FAIL b2b_bcd got %h want 042", if3.bcd); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        if3.start = 1'b1; if3.bin = 8'd200;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (if3.busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy got %b want 0", if3.busy); end
        n_cmp++; if (if3.bcd !== 12'h000) begin n_err++; $display("[TB] FAIL midrst_bcd got %h want 000", if3.bcd); end
        n_cmp++; if (if3.done !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_done got %b want 0", if3.done); end
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (if3.done) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", done_seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if3.start = 1'b0; if3.bin = '0;
        if2.start = 1'b0; if2.bin = '0;
        test_reset();
        test_zero();
        test_max();
        test_sweep();
        test_two_digits();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
